ddr3_rw_checker: RTL

DDR3_RW_CHECKER -- requirements
Module: ddr3_rw_checker

---
 rtl/ddr3_test_pkg.sv | 14 +
 rtl/ddr3_rw_checker_if.sv | 26 ++
 rtl/ddr3_rd_compare.sv | 63 ++++++
 rtl/ddr3_rw_checker.sv | 131 +++++++++++++
 4 files changed

// File: rtl/ddr3_test_pkg.sv
// Shared types and command encodings for the DDR3 read/write checker.
package ddr3_test_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

endpackage

// File: rtl/ddr3_rw_checker_if.sv
// MIG-style application port: command, write-data and read-return channels.
interface ddr3_rw_checker_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 28
);
    logic              app_en;
    logic [2:0]        app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic              app_rdy;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic [DATA_W-1:0] app_wdf_data;
    logic              app_wdf_rdy;
    logic              app_rd_data_valid;
    logic [DATA_W-1:0] app_rd_data;

    modport master (
        output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data,
        input  app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data
    );

    modport slave (
        input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data,
        output app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data
    );
endinterface

// File: rtl/ddr3_rd_compare.sv
// Read-return checker: counts returns, regenerates the expected pattern and
// keeps a sticky mismatch flag plus a per-pass error/done status.
module ddr3_rd_compare
    import ddr3_test_pkg::*;
#(
    parameter int DATA_W   = 128,
    parameter int TEST_LEN = 512
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              init_calib_complete,
    input  logic              restart,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              returns_done,
    output logic              pass_err,
    output logic              error_flag
);
    localparam logic [15:0] LAST_IDX = 16'(TEST_LEN - 1);

    logic [15:0]       exp_idx_reg;
    logic              returns_done_reg;
    logic              pass_err_reg;
    logic              error_flag_reg;
    logic [DATA_W-1:0] exp_word;

    assign exp_word = {(DATA_W/16){exp_idx_reg}};

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            exp_idx_reg      <= '0;
            returns_done_reg <= 1'b0;
            pass_err_reg     <= 1'b0;
            error_flag_reg   <= 1'b0;
        end else if (!init_calib_complete) begin
            // error_flag survives a calibration loss; only the pass state is cleared
            exp_idx_reg      <= '0;
            returns_done_reg <= 1'b0;
            pass_err_reg     <= 1'b0;
        end else begin
            if (restart) begin
                returns_done_reg <= 1'b0;
                pass_err_reg     <= 1'b0;
            end
            if (rd_valid) begin
                if (rd_data != exp_word) begin
                    pass_err_reg   <= 1'b1;
                    error_flag_reg <= 1'b1;
                end
                if (exp_idx_reg == LAST_IDX) begin
                    exp_idx_reg      <= '0;
                    returns_done_reg <= 1'b1;
                end else begin
                    exp_idx_reg <= exp_idx_reg + 16'd1;
                end
            end
        end
    end

    assign returns_done = returns_done_reg;
    assign pass_err     = pass_err_reg;
    assign error_flag   = error_flag_reg;
endmodule

// File: rtl/ddr3_rw_checker.sv
// DDR3 memory test: writes TEST_LEN index patterns, reads them back and checks.
// Define DDR3_ERR_INJECT_EN to flip bit 0 of word 0 on every write pass.
module ddr3_rw_checker
    import ddr3_test_pkg::*;
#(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 28,
    parameter int TEST_LEN  = 512,
    parameter int ADDR_STEP = 8
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              init_calib_complete,
    ddr3_rw_checker_if.master app,
    output logic              error_flag,
    output logic              pass_done
);
    localparam logic [15:0] LAST_IDX = 16'(TEST_LEN - 1);

    state_t            state_reg;
    logic [15:0]       idx_reg;
    logic              app_en_reg;
    logic              wren_reg;
    logic [2:0]        cmd_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              pass_done_reg;
    logic              returns_done;
    logic              pass_err;
    logic              restart;
    logic              start_write;

    function automatic logic [DATA_W-1:0] wr_word(input logic [15:0] idx);
        logic [DATA_W-1:0] w;
        w = {(DATA_W/16){idx}};
`ifdef DDR3_ERR_INJECT_EN
        if (idx == 16'd0) w[0] = ~w[0];
`endif
        return w;
    endfunction

    assign start_write = (state_reg == IDLE) || (state_reg == DRAIN && returns_done);
    assign restart     = init_calib_complete && (state_reg == DRAIN) && returns_done;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            app_en_reg    <= 1'b0;
            wren_reg      <= 1'b0;
            cmd_reg       <= CMD_WR;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            pass_done_reg <= 1'b0;
        end else begin
            pass_done_reg <= 1'b0;
            if (!init_calib_complete) begin
                state_reg  <= IDLE;
                idx_reg    <= '0;
                app_en_reg <= 1'b0;
                wren_reg   <= 1'b0;
                cmd_reg    <= CMD_WR;
                addr_reg   <= '0;
            end else if (start_write) begin
                // outputs are loaded with word 0 so the first write goes out on state entry
                state_reg     <= WRITE;
                idx_reg       <= '0;
                app_en_reg    <= 1'b1;
                wren_reg      <= 1'b1;
                cmd_reg       <= CMD_WR;
                addr_reg      <= '0;
                wdata_reg     <= wr_word(16'd0);
                pass_done_reg <= (state_reg == DRAIN) && !pass_err;
            end else begin
                case (state_reg)
                    WRITE: begin
                        if (app.app_rdy && app.app_wdf_rdy) begin
                            if (idx_reg == LAST_IDX) begin
                                state_reg <= READ;
                                idx_reg   <= '0;
                                wren_reg  <= 1'b0;
                                cmd_reg   <= CMD_RD;
                                addr_reg  <= '0;
                            end else begin
                                idx_reg   <= idx_reg + 16'd1;
                                addr_reg  <= addr_reg + ADDR_W'(ADDR_STEP);
                                wdata_reg <= wr_word(idx_reg + 16'd1);
                            end
                        end
                    end
                    READ: begin
                        if (app.app_rdy) begin
                            if (idx_reg == LAST_IDX) begin
                                state_reg  <= DRAIN;
                                idx_reg    <= '0;
                                app_en_reg <= 1'b0;
                            end else begin
                                idx_reg  <= idx_reg + 16'd1;
                                addr_reg <= addr_reg + ADDR_W'(ADDR_STEP);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    ddr3_rd_compare #(
        .DATA_W   (DATA_W),
        .TEST_LEN (TEST_LEN)
    ) u_rd_compare (
        .clk_50m             (clk_50m),
        .rst_n               (rst_n),
        .init_calib_complete (init_calib_complete),
        .restart             (restart),
        .rd_valid            (app.app_rd_data_valid),
        .rd_data             (app.app_rd_data),
        .returns_done        (returns_done),
        .pass_err            (pass_err),
        .error_flag          (error_flag)
    );

    assign app.app_en       = app_en_reg;
    assign app.app_cmd      = cmd_reg;
    assign app.app_addr     = addr_reg;
    assign app.app_wdf_wren = wren_reg;
    assign app.app_wdf_end  = wren_reg;
    assign app.app_wdf_data = wdata_reg;
    assign pass_done        = pass_done_reg;
endmodule
